// File: rtl/dff_prcl_pkg.sv
// -----------------------------------------------------------------------------
// dff_prcl_pkg
// Shared definitions for the preset/clear D flip-flop cell.
//   ACT_PRE / ACT_CLR : active level of the preset and clear controls (low).
//   dff_op_e          : the single operation a cell performs, after priority.
//   resolve_op        : collapses the control inputs into one dff_op_e.
// Optional build macro used elsewhere in this slice: DFF_PRCL_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package dff_prcl_pkg;

    localparam logic ACT_PRE = 1'b0;
    localparam logic ACT_CLR = 1'b0;

    typedef enum logic [2:0] {
        HOLD,
        CAPTURE,
        RESET,
        PRESET,
        CLEAR
    } dff_op_e;

    // Clear beats preset, and both beat anything that needs a clock edge.
    // Without an edge and with no forcing control active, the cell holds.
    function automatic dff_op_e resolve_op(
        input logic i_edge,
        input logic i_preb,
        input logic i_clrb,
        input logic i_rst
    );
        dff_op_e w_op;
        if (i_clrb == ACT_CLR) begin
            w_op = CLEAR;
        end else if (i_preb == ACT_PRE) begin
            w_op = PRESET;
        end else if (!i_edge) begin
            w_op = HOLD;
        end else if (i_rst) begin
            w_op = RESET;
        end else begin
            w_op = CAPTURE;
        end
        return w_op;
    endfunction

endpackage

// File: rtl/dff_prcl_bit.sv
// -----------------------------------------------------------------------------
// dff_prcl_bit
// One-bit D storage cell with asynchronous active-low preset and clear and a
// synchronous active-high reset.
// Ports:
//   i_clk  : clock, captures on the rising edge
//   i_rst  : synchronous reset, loads RESET_VAL
//   i_d    : data input
//   i_preb : asynchronous preset, active low
//   i_clrb : asynchronous clear, active low (wins over preset)
//   o_q    : stored value
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dff_prcl_bit
    import dff_prcl_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    input  logic i_preb,
    input  logic i_clrb,
    output logic o_q
);

    logic r_q;

    // The forcing controls are written as explicit tests ahead of the clocked
    // branch so the block maps onto a flop with async set and reset pins.
    // A release of preset or clear is not an event here, so the forced value
    // is held until the next rising clock edge.
    always_ff @(posedge i_clk or negedge i_preb or negedge i_clrb) begin
        if (i_clrb == ACT_CLR) begin
            r_q <= 1'b0;
        end else if (i_preb == ACT_PRE) begin
            r_q <= 1'b1;
        end else begin
            case (resolve_op(1'b1, i_preb, i_clrb, i_rst))
                RESET:   r_q <= RESET_VAL;
                default: r_q <= i_d;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/d_flip_flop_prcl.sv
// -----------------------------------------------------------------------------
// d_flip_flop_prcl
// WIDTH-bit D flip-flop with active-low asynchronous preset (PREB) and clear
// (CLRB), synchronous active-high reset (rst) and complementary outputs.
// Each bit is an independent dff_prcl_bit; all bits share C, rst, PREB, CLRB.
// Ports:
//   C    : clock, rising edge
//   rst  : synchronous reset, loads RESET_VAL
//   DD   : data input, WIDTH bits
//   PREB : asynchronous preset, active low, forces Q to all ones
//   CLRB : asynchronous clear, active low, forces Q to zero (wins)
//   Q    : stored value
//   Qbar : always ~Q
// Build macro: DFF_PRCL_CHECK_EN compiles in concurrent assertions on Qbar,
// the forcing controls and the one-edge capture latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module d_flip_flop_prcl
    import dff_prcl_pkg::*;
#(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             C,
    input  logic             rst,
    input  logic [WIDTH-1:0] DD,
    input  logic             PREB,
    input  logic             CLRB,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    logic [WIDTH-1:0] w_q;

    // One cell per bit, each picking up its own slice of the reset value.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        dff_prcl_bit #(
            .RESET_VAL (RESET_VAL[g])
        ) u_bit (
            .i_clk  (C),
            .i_rst  (rst),
            .i_d    (DD[g]),
            .i_preb (PREB),
            .i_clrb (CLRB),
            .o_q    (w_q[g])
        );
    end

    // Qbar is derived, never stored, so it cannot disagree with Q.
    assign Q    = w_q;
    assign Qbar = ~w_q;

`ifdef DFF_PRCL_CHECK_EN
    a_qbar_complement : assert property (@(posedge C) disable iff (rst)
        Qbar == ~Q)
        else $error("Qbar is not the complement of Q");

    a_clear_forces_zero : assert property (@(posedge C) disable iff (rst)
        (CLRB == ACT_CLR) |-> (Q == '0))
        else $error("Q not zero while clear is active");

    a_preset_forces_ones : assert property (@(posedge C) disable iff (rst)
        ((PREB == ACT_PRE) && (CLRB != ACT_CLR)) |-> (Q == '1))
        else $error("Q not all ones while preset is active");

    a_capture_latency : assert property (@(posedge C) disable iff (rst)
        ((PREB != ACT_PRE) && (CLRB != ACT_CLR) && !rst)
            ##1 ((PREB != ACT_PRE) && (CLRB != ACT_CLR))
            |-> (Q == $past(DD)))
        else $error("Q does not hold the data captured at the previous edge");
`else
    // No checks compiled in this build.
`endif

endmodule

// File: tb/tb_d_flip_flop_prcl.sv
// -----------------------------------------------------------------------------
// tb_d_flip_flop_prcl
// Self-checking bench for d_flip_flop_prcl with WIDTH=1, RESET_VAL=0.
// Inputs change a quarter period after each rising edge; outputs are sampled
// 1 ns after a rising edge or after an input change.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_d_flip_flop_prcl;

    localparam int   WIDTH     = 1;
    localparam logic RESET_VAL = 1'b0;

    logic C;
    logic rst;
    logic DD;
    logic PREB;
    logic CLRB;
    logic Q;
    logic Qbar;

    int checks;
    int errors;

    d_flip_flop_prcl #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .C    (C),
        .rst  (rst),
        .DD   (DD),
        .PREB (PREB),
        .CLRB (CLRB),
        .Q    (Q),
        .Qbar (Qbar)
    );

    // 1000 ns clock period
    initial C = 1'b0;
    always #500 C = ~C;

    // Hard stop in case something stalls the sequence
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Move to the next rising edge, then to the middle of the high phase
    task automatic next_mid();
        @(posedge C);
        #250;
    endtask

    // Move to 1 ns after the next rising edge
    task automatic after_edge();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        PREB = 1'b1;
        CLRB = 1'b1;
        DD   = 1'b1;
        @(posedge C);
        @(posedge C);
        #250;
        rst = 1'b0;
        DD  = 1'b0;
        #1;
        checks++;
        if (Q !== RESET_VAL) begin
            errors++;
            $display("[TB] FAIL reset_q got %b want %b", Q, RESET_VAL);
        end
        checks++;
        if (Qbar !== ~RESET_VAL) begin
            errors++;
            $display("[TB] FAIL reset_qbar got %b want %b", Qbar, ~RESET_VAL);
        end
    endtask

    task automatic test_capture();
        next_mid();
        DD = 1'b1;
        #1;
        checks++;
        if (Q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL capture_between_edges_1 got %b want %b", Q, 1'b0);
        end
        after_edge();
        checks++;
        if (Q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL capture_one got %b want %b", Q, 1'b1);
        end
        @(posedge C);
        #749;
        DD = 1'b0;
        #1;
        checks++;
        if (Q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL capture_between_edges_0 got %b want %b", Q, 1'b1);
        end
        after_edge();
        checks++;
        if (Q !== 1'b0 || Qbar !== 1'b1) begin
            errors++;
            $display("[TB] FAIL capture_zero got Q=%b Qbar=%b want Q=0 Qbar=1", Q, Qbar);
        end
    endtask

    task automatic test_preset();
        next_mid();
        PREB = 1'b0;
        #1;
        checks++;
        if (Q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL preset_immediate got %b want %b", Q, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            next_mid();
            DD = ~DD;
            after_edge();
            checks++;
            if (Q !== 1'b1 || Qbar !== 1'b0) begin
                errors++;
                $display("[TB] FAIL preset_hold_%0d got Q=%b Qbar=%b want Q=1 Qbar=0", i, Q, Qbar);
            end
        end
        #249;
        DD   = 1'b0;
        PREB = 1'b1;
        #1;
        checks++;
        if (Q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL preset_release_hold got %b want %b", Q, 1'b1);
        end
        after_edge();
        checks++;
        if (Q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL preset_release_load got %b want %b", Q, 1'b0);
        end
    endtask

    task automatic test_clear();
        next_mid();
        DD = 1'b1;
        after_edge();
        #249;
        CLRB = 1'b0;
        #1;
        checks++;
        if (Q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_immediate got %b want %b", Q, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            next_mid();
            DD = ~DD;
            after_edge();
            checks++;
            if (Q !== 1'b0 || Qbar !== 1'b1) begin
                errors++;
                $display("[TB] FAIL clear_hold_%0d got Q=%b Qbar=%b want Q=0 Qbar=1", i, Q, Qbar);
            end
        end
        #249;
        DD   = 1'b1;
        CLRB = 1'b1;
        #1;
        checks++;
        if (Q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_release_hold got %b want %b", Q, 1'b0);
        end
        after_edge();
        checks++;
        if (Q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_release_load got %b want %b", Q, 1'b1);
        end
    endtask

    task automatic test_both_low();
        next_mid();
        CLRB = 1'b0;
        next_mid();
        PREB = 1'b0;
        DD   = 1'b1;
        #1;
        checks++;
        if (Q !== 1'b0 || Qbar !== 1'b1) begin
            errors++;
            $display("[TB] FAIL both_low_entry got Q=%b Qbar=%b want Q=0 Qbar=1", Q, Qbar);
        end
        for (int i = 0; i < 3; i++) begin
            after_edge();
            checks++;
            if (Q !== 1'b0 || Qbar !== 1'b1) begin
                errors++;
                $display("[TB] FAIL both_low_hold_%0d got Q=%b Qbar=%b want Q=0 Qbar=1", i, Q, Qbar);
            end
        end
        next_mid();
        PREB = 1'b1;
        next_mid();
        CLRB = 1'b1;
        after_edge();
        checks++;
        if (Q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL both_low_release got %b want %b", Q, 1'b1);
        end
    endtask

    task automatic test_rst_preset();
        next_mid();
        DD   = 1'b0;
        rst  = 1'b1;
        PREB = 1'b0;
        for (int i = 0; i < 2; i++) begin
            after_edge();
            checks++;
            if (Q !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rst_preset_wins_%0d got %b want %b", i, Q, 1'b1);
            end
        end
        #249;
        DD   = 1'b1;
        PREB = 1'b1;
        after_edge();
        checks++;
        if (Q !== RESET_VAL) begin
            errors++;
            $display("[TB] FAIL rst_after_preset got %b want %b", Q, RESET_VAL);
        end
        #249;
        rst = 1'b0;
        after_edge();
        checks++;
        if (Q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_release_capture got %b want %b", Q, 1'b1);
        end
    endtask

    // Random traffic against a reference built from the behavioural rules:
    // asserting a forcing control changes Q at once, releasing it changes
    // nothing, and each rising edge applies clear > preset > reset > data.
    task automatic test_random();
        logic expQ;
        logic newPreb;
        logic newClrb;
        expQ = Q;
        for (int i = 0; i < 200; i++) begin
            next_mid();
            newClrb = ($urandom_range(0, 5) != 0);
            newPreb = ($urandom_range(0, 5) != 0);
            // Releasing clear while preset stays low is left out of the mix.
            if (newClrb && !CLRB && !newPreb && !PREB) newPreb = 1'b1;
            DD   = 1'($urandom);
            rst  = ($urandom_range(0, 7) == 0);
            PREB = newPreb;
            CLRB = newClrb;
            if (!CLRB)      expQ = 1'b0;
            else if (!PREB) expQ = 1'b1;
            #1;
            checks++;
            if (Q !== expQ || Qbar !== ~expQ) begin
                errors++;
                $display("[TB] FAIL random_mid_%0d got Q=%b Qbar=%b want Q=%b", i, Q, Qbar, expQ);
            end
            @(posedge C);
            if (!CLRB)      expQ = 1'b0;
            else if (!PREB) expQ = 1'b1;
            else if (rst)   expQ = RESET_VAL;
            else            expQ = DD;
            #1;
            checks++;
            if (Q !== expQ || Qbar !== ~expQ) begin
                errors++;
                $display("[TB] FAIL random_edge_%0d got Q=%b Qbar=%b want Q=%b", i, Q, Qbar, expQ);
            end
            #248;
        end
        PREB = 1'b1;
        CLRB = 1'b1;
        rst  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        PREB   = 1'b1;
        CLRB   = 1'b1;
        DD     = 1'b0;
        test_reset();
        test_capture();
        test_preset();
        test_clear();
        test_both_low();
        test_rst_preset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
